// File: rtl/uart_rx_sequencer.sv
// ---------------------------------------------------------------------------
// uart_rx_sequencer
//   Control sequencer for a UART receive path. Double-flops the asynchronous
//   serial line, qualifies the start bit at mid-bit, samples each data bit at
//   the end of its oversample window, shifts data LSB-first, checks the stop
//   bit and emits either a one-cycle rx_valid or frame_err pulse. Counters
//   and state only advance on baud_tick; the pulses clear on the next clk.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   synchronous, active-low reset (0 = reset)
//   baud_tick  in   one-cycle oversample strobe
//   data_in    in   asynchronous serial line, idle high
//   rx_data    out  last good byte, LSB = first data bit received
//   rx_valid   out  one-cycle pulse: rx_data updated with a good frame
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   busy       out  high in every state except IDLE
//   bic        out  bit index (0 idle/start, 1..DATA_BITS data, DATA_BITS+1 stop)
//   shift_en   out  one-cycle pulse on each data-bit sample
// ---------------------------------------------------------------------------
module uart_rx_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [3:0]           bic,
  output logic                 shift_en
);

  localparam int BSC_W = $clog2(OVERSAMPLE);

  localparam logic [BSC_W-1:0] BSC_HALF = BSC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BSC_W-1:0] BSC_FULL = BSC_W'(OVERSAMPLE - 1);

  localparam logic [3:0] BIC_PRE  = 4'(DATA_BITS - 1);
  localparam logic [3:0] BIC_LAST = 4'(DATA_BITS);
  localparam logic [3:0] BIC_STOP = 4'(DATA_BITS + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BRK   = 3'd4;

  logic [2:0]           state;
  logic [BSC_W-1:0]     bsc;
  logic                 s1;
  logic                 s2;
  logic [DATA_BITS-1:0] shreg;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bsc       <= '0;
      bic       <= '0;
      s1        <= 1'b1;
      s2        <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      shift_en  <= 1'b0;
    end else begin
      // Synchroniser stage: runs every clk regardless of baud_tick
      s1 <= data_in;
      s2 <= s1;

      // Pulse outputs live for exactly one clk
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      shift_en  <= 1'b0;

      // Sequencer stage: advances only on oversample ticks
      if (baud_tick) begin
        case (state)
          ST_IDLE: begin
            if (!s2) begin
              state <= ST_START;
              bsc   <= '0;
            end
          end

          ST_START: begin
            if (bsc != BSC_HALF) begin
              bsc <= bsc + 1'b1;
            end else begin
              bsc <= '0;
              // Line back high at mid-start means a glitch, not a frame
              state <= s2 ? ST_IDLE : ST_DATA;
              bic   <= '0;
            end
          end

          ST_DATA: begin
            if (bsc != BSC_FULL) begin
              bsc <= bsc + 1'b1;
            end else begin
              bsc      <= '0;
              shreg    <= {s2, shreg[DATA_BITS-1:1]};
              shift_en <= 1'b1;
              bic      <= bic + 4'd1;
              if (bic == BIC_PRE) state <= ST_STOP;
            end
          end

          ST_STOP: begin
            // bic shows DATA_BITS for one tick after the last shift, then
            // moves to the stop index
            if (bic == BIC_LAST) bic <= BIC_STOP;
            if (bsc != BSC_FULL) begin
              bsc <= bsc + 1'b1;
            end else begin
              bsc <= '0;
              bic <= '0;
              if (s2) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                state    <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_BRK;
              end
            end
          end

          ST_BRK: begin
            // A held break reports once; wait for the line to recover
            if (s2) state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
            bsc   <= '0;
            bic   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sequencer
//   Self-checking bench for uart_rx_sequencer. Frames are driven as line
//   levels per bit period; a frame-level model predicts each received byte or
//   framing error and the clock edge of its pulse from the tick schedule.
// ---------------------------------------------------------------------------
module tb_uart_rx_sequencer;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          baud_tick = 1'b0;
  logic          data_in = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;
  logic [3:0]    bic;
  logic          shift_en;

  always #5 clk = ~clk;

  uart_rx_sequencer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .data_in   (data_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .bic       (bic),
    .shift_en  (shift_en)
  );

  typedef struct {
    logic          err;
    logic [DB-1:0] data;
    int            edge_n;
  } ev_t;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int div = 1;
  int phase = 0;
  logic [DB-1:0] last_good = '0;
  ev_t got_q[$];
  ev_t exp_q[$];
  int bic_hist[$];
  int shift_cnt = 0;
  logic [3:0] bic_prev = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Output monitor
  always @(negedge clk) begin
    if (rx_valid === 1'b1) got_q.push_back('{1'b0, rx_data, edge_cnt});
    if (frame_err === 1'b1) got_q.push_back('{1'b1, rx_data, edge_cnt});
    if (shift_en === 1'b1) shift_cnt++;
    if (bic !== bic_prev) begin
      bic_hist.push_back(int'(bic));
      bic_prev = bic;
    end
    if (reset === 1'b1) begin
      checks++;
      if ((rx_valid === 1'b1 && frame_err === 1'b1) || (bic > 4'(DB + 1))) begin
        errors++;
        $display("FAIL invariant at edge %0d: rx_valid=%b frame_err=%b bic=%0d (need not both, bic<=%0d)",
                 edge_cnt, rx_valid, frame_err, bic, DB + 1);
      end
    end
  end

  task automatic drive_one(input logic lvl);
    @(negedge clk);
    data_in   = lvl;
    baud_tick = (phase == 0);
    phase     = (phase + 1 >= div) ? 0 : phase + 1;
  endtask

  task automatic drive_n(input logic lvl, input int n);
    for (int i = 0; i < n; i++) drive_one(lvl);
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    bic_hist.delete();
    shift_cnt = 0;
  endtask

  // Drives one complete frame and queues the model's expected outcome.
  // Detection needs two synchroniser edges, then the first tick; the stop
  // sample lies 8 + 9*16 = 152 ticks after detection.
  task automatic send_frame(input logic [DB-1:0] b, input logic stop, output int start_edge);
    int ph0;
    int det;
    ev_t e;
    ph0 = phase;
    drive_one(1'b0);
    start_edge = edge_cnt + 1;
    det = start_edge + 2;
    for (int j = 2; j < 2 + div; j++) begin
      if ((ph0 + j) % div == 0) begin
        det = start_edge + j;
        break;
      end
    end
    e.err    = !stop;
    e.data   = stop ? b : last_good;
    e.edge_n = det + 152 * div;
    exp_q.push_back(e);
    if (stop) last_good = b;
    drive_n(1'b0, OS * div - 1);
    for (int i = 0; i < DB; i++) drive_n(b[i], OS * div);
    drive_n(stop, OS * div);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_n(1'b1, 4);
    checks++;
    if ({rx_data, rx_valid, frame_err, busy, bic, shift_en} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rx_data=%h valid=%b ferr=%b busy=%b bic=%0d shift_en=%b, all must be 0",
               rx_data, rx_valid, frame_err, busy, bic, shift_en);
    end
    reset = 1'b1;
    drive_n(1'b1, 4);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b need 0", busy);
    end
    last_good = '0;
  endtask

  task automatic test_frame_a5();
    int st;
    int exp_bic[$];
    clear_obs();
    send_frame(8'hA5, 1'b1, st);
    drive_n(1'b1, 20);
    for (int i = 1; i <= DB + 1; i++) exp_bic.push_back(i);
    exp_bic.push_back(0);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL a5_count: got %0d events need 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].err !== 1'b0 || got_q[0].data !== 8'hA5) begin
        errors++;
        $display("FAIL a5_data: got err=%b data=%h need err=0 data=a5", got_q[0].err, got_q[0].data);
      end
      checks++;
      if (got_q[0].edge_n - st + 1 != 155) begin
        errors++;
        $display("FAIL a5_timing: rx_valid after edge %0d need 155", got_q[0].edge_n - st + 1);
      end
    end
    checks++;
    if (shift_cnt != DB) begin
      errors++;
      $display("FAIL a5_shift_en: got %0d pulses need %0d", shift_cnt, DB);
    end
    checks++;
    if (bic_hist != exp_bic) begin
      errors++;
      $display("FAIL a5_bic_seq: got %p need %p", bic_hist, exp_bic);
    end
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL a5_rx_data_hold: got %h need a5", rx_data);
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    drive_n(1'b0, 5);
    drive_n(1'b1, 6);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_start: got %b need 1 after edge 10", busy);
    end
    drive_one(1'b1);
    checks++;
    if (busy !== 1'b0 || bic !== 4'd0) begin
      errors++;
      $display("FAIL glitch_idle: busy=%b bic=%0d after edge 11, need 0 and 0", busy, bic);
    end
    drive_n(1'b1, 40);
    checks++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_output: events=%0d busy=%b need 0 and 0", got_q.size(), busy);
    end
  endtask

  task automatic test_break();
    int st;
    logic [DB-1:0] prior;
    clear_obs();
    prior = last_good;
    send_frame(8'h3C, 1'b0, st);
    drive_n(1'b0, 40 * OS);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL brk_held: busy=%b during break need 1", busy);
    end
    checks++;
    if (rx_data !== prior) begin
      errors++;
      $display("FAIL brk_rx_data: got %h need %h", rx_data, prior);
    end
    drive_n(1'b1, 40);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL brk_exit: busy=%b after line high need 0", busy);
    end
    send_frame(8'h81, 1'b1, st);
    drive_n(1'b1, 40);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL brk_events: got %0d events need %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] != exp_q[i]) begin
          errors++;
          $display("FAIL brk_event%0d: got err=%b data=%h edge=%0d need err=%b data=%h edge=%0d", i,
                   got_q[i].err, got_q[i].data, got_q[i].edge_n, exp_q[i].err, exp_q[i].data, exp_q[i].edge_n);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int st;
    clear_obs();
    send_frame(8'h00, 1'b1, st);
    send_frame(8'hFF, 1'b1, st);
    drive_n(1'b1, 40);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d events need 2", got_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] != exp_q[i]) begin
          errors++;
          $display("FAIL b2b_event%0d: got err=%b data=%h edge=%0d need err=%b data=%h edge=%0d", i,
                   got_q[i].err, got_q[i].data, got_q[i].edge_n, exp_q[i].err, exp_q[i].data, exp_q[i].edge_n);
        end
      end
    end
  endtask

  task automatic test_slow_tick();
    int st;
    clear_obs();
    div = 4;
    phase = 0;
    send_frame(8'h5A, 1'b1, st);
    drive_n(1'b1, 40 * div);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL slow_count: got %0d events need 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] != exp_q[0]) begin
        errors++;
        $display("FAIL slow_event: got data=%h edge=%0d need data=%h edge=%0d",
                 got_q[0].data, got_q[0].edge_n - st + 1, exp_q[0].data, exp_q[0].edge_n - st + 1);
      end
    end
    checks++;
    if (shift_cnt != DB) begin
      errors++;
      $display("FAIL slow_shift_en: got %0d pulses need %0d", shift_cnt, DB);
    end
    div = 1;
    phase = 0;
  endtask

  task automatic test_reset_mid_frame();
    int st;
    logic [DB-1:0] b;
    clear_obs();
    b = 8'hC3;
    drive_n(1'b0, OS);
    for (int i = 0; i < 4; i++) drive_n(b[i], OS);
    checks++;
    if (bic !== 4'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: bic=%0d busy=%b need 4 and 1", bic, busy);
    end
    drive_one(1'b1);
    reset = 1'b0;
    drive_one(1'b1);
    checks++;
    if ({rx_data, rx_valid, frame_err, busy, bic, shift_en} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: rx_data=%h valid=%b ferr=%b busy=%b bic=%0d shift_en=%b, all must be 0",
               rx_data, rx_valid, frame_err, busy, bic, shift_en);
    end
    reset = 1'b1;
    last_good = '0;
    drive_n(1'b1, 40);
    checks++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: events=%0d busy=%b need 0 and 0", got_q.size(), busy);
    end
    send_frame(b, 1'b1, st);
    drive_n(1'b1, 40);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL midrst_count: got %0d events need 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] != exp_q[0]) begin
        errors++;
        $display("FAIL midrst_event: got err=%b data=%h edge=%0d need err=%b data=%h edge=%0d",
                 got_q[0].err, got_q[0].data, got_q[0].edge_n, exp_q[0].err, exp_q[0].data, exp_q[0].edge_n);
      end
    end
  endtask

  task automatic test_random();
    int st;
    int nd;
    int gap;
    logic stop;
    logic [DB-1:0] b;
    clear_obs();
    for (int f = 0; f < 10; f++) begin
      nd = $urandom_range(1, 3);
      if (nd != div) begin
        div = nd;
        phase = 0;
      end
      b    = DB'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, st);
      gap = $urandom_range(0, 12) + (stop ? 0 : 4 * div + 4);
      drive_n(1'b1, gap);
    end
    drive_n(1'b1, 40 * div);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d events need %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] != exp_q[i]) begin
          errors++;
          $display("FAIL rand_event%0d: got err=%b data=%h edge=%0d need err=%b data=%h edge=%0d", i,
                   got_q[i].err, got_q[i].data, got_q[i].edge_n, exp_q[i].err, exp_q[i].data, exp_q[i].edge_n);
        end
      end
    end
    checks++;
    if (rx_data !== last_good) begin
      errors++;
      $display("FAIL rand_rx_data: got %h need %h", rx_data, last_good);
    end
    div = 1;
    phase = 0;
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_break();
    test_back_to_back();
    test_slow_tick();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
